// File: rtl/alu_result_stage.sv
// alu_result_stage: registered per-lane ALU result select with NZP flag
// register and a valid/ready output stage.
// Optional feature macro: ALU_RESULT_STAGE_SKID_EN
//   defined   -> 2-entry skid buffer, InReady depends on occupancy only
//   undefined -> single output register, InReady = !OutValid || OutReady
module alu_result_stage #(
  parameter int WIDTH   = 8,
  parameter int THREADS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic                     ALUOutputMux,
  input  logic [THREADS*WIDTH-1:0] ArithOut,
  input  logic [THREADS*3-1:0]     CmpOut,
  input  logic [THREADS-1:0]       ThreadMask,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [THREADS*WIDTH-1:0] ALUOut,
  output logic [THREADS-1:0]       LaneMaskOut,
  output logic [THREADS*3-1:0]     NZP
);

  localparam int DW = THREADS * WIDTH;

  // Per-lane payload: arithmetic result, or the flags bit-reversed into the
  // low three bits (P at bit 2, N at bit 0); masked lanes carry zero.
  function automatic logic [DW-1:0] select_payload(
    input logic                 flag_mode,
    input logic [DW-1:0]        arith,
    input logic [THREADS*3-1:0] cmp,
    input logic [THREADS-1:0]   mask
  );
    logic [DW-1:0]    res;
    logic [WIDTH-1:0] lane;
    res = '0;
    for (int t = 0; t < THREADS; t++) begin
      lane = '0;
      if (!mask[t]) begin
        lane = '0;
      end else if (flag_mode) begin
        lane[2] = cmp[t*3 + 0];
        lane[1] = cmp[t*3 + 1];
        lane[0] = cmp[t*3 + 2];
      end else begin
        lane = arith[t*WIDTH +: WIDTH];
      end
      res[t*WIDTH +: WIDTH] = lane;
    end
    return res;
  endfunction

  logic [DW-1:0]        payload_s;
  logic                 in_ready_s;
  logic                 accept_s;
  logic                 drain_s;
  logic                 out_valid_r;
  logic [DW-1:0]        head_data_r;
  logic [THREADS-1:0]   head_mask_r;
  logic [THREADS*3-1:0] nzp_r;

`ifdef ALU_RESULT_STAGE_SKID_EN
  logic [1:0]           count_r;
  logic [DW-1:0]        skid_data_r;
  logic [THREADS-1:0]   skid_mask_r;

  // Ready depends on occupancy only, never on downstream ready.
  always_comb begin
    in_ready_s = 1'b0;
    if (reset) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = (count_r < 2'd2);
    end
  end

  // Two-entry FIFO: head register drives the outputs, skid holds the second bundle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r     <= 2'd0;
      out_valid_r <= 1'b0;
      head_data_r <= '0;
      head_mask_r <= '0;
      skid_data_r <= '0;
      skid_mask_r <= '0;
    end else begin
      case ({accept_s, drain_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_data_r <= payload_s;
            head_mask_r <= ThreadMask;
            out_valid_r <= 1'b1;
            count_r     <= 2'd1;
          end else begin
            skid_data_r <= payload_s;
            skid_mask_r <= ThreadMask;
            count_r     <= 2'd2;
          end
        end
        2'b01: begin
          if (count_r == 2'd2) begin
            head_data_r <= skid_data_r;
            head_mask_r <= skid_mask_r;
            count_r     <= 2'd1;
          end else begin
            out_valid_r <= 1'b0;
            count_r     <= 2'd0;
          end
        end
        // Only reachable at occupancy 1: the new bundle replaces the head.
        2'b11: begin
          head_data_r <= payload_s;
          head_mask_r <= ThreadMask;
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end
`else
  // Single register: accept whenever the register is empty or draining now.
  always_comb begin
    in_ready_s = 1'b0;
    if (reset) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = !out_valid_r || OutReady;
    end
  end

  // Output register load on accept, invalidate on drain without refill.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      head_data_r <= '0;
      head_mask_r <= '0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      head_data_r <= payload_s;
      head_mask_r <= ThreadMask;
    end else if (drain_s) begin
      out_valid_r <= 1'b0;
    end
  end
`endif

  // Handshake qualifiers and the payload of the bundle being offered.
  always_comb begin
    accept_s  = InValid && in_ready_s;
    drain_s   = out_valid_r && OutReady;
    payload_s = select_payload(ALUOutputMux, ArithOut, CmpOut, ThreadMask);
  end

  // NZP loads at the accept edge of flag-mode bundles, active lanes only.
  always_ff @(posedge clk) begin
    if (reset) begin
      nzp_r <= '0;
    end else begin
      for (int t = 0; t < THREADS; t++) begin
        if (accept_s && ALUOutputMux && ThreadMask[t]) begin
          nzp_r[t*3 +: 3] <= CmpOut[t*3 +: 3];
        end
      end
    end
  end

  assign InReady     = in_ready_s;
  assign OutValid    = out_valid_r;
  assign ALUOut      = head_data_r;
  assign LaneMaskOut = head_mask_r;
  assign NZP         = nzp_r;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage (WIDTH=8, THREADS=4).
// A queue scoreboard models buffer contents; NZP is modelled separately.
module tb_alu_result_stage;

  localparam int W = 8;
  localparam int T = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           InValid;
  logic           InReady;
  logic           ALUOutputMux;
  logic [T*W-1:0] ArithOut;
  logic [T*3-1:0] CmpOut;
  logic [T-1:0]   ThreadMask;
  logic           OutValid;
  logic           OutReady;
  logic [T*W-1:0] ALUOut;
  logic [T-1:0]   LaneMaskOut;
  logic [T*3-1:0] NZP;

  typedef struct {
    logic [T*W-1:0] data;
    logic [T-1:0]   mask;
  } bundle_t;

  bundle_t        q[$];
  logic [T*3-1:0] exp_nzp;
  int             checks = 0;
  int             errors = 0;
  int             ov_count;

  alu_result_stage #(.WIDTH(W), .THREADS(T)) dut (
    .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady),
    .ALUOutputMux(ALUOutputMux), .ArithOut(ArithOut), .CmpOut(CmpOut),
    .ThreadMask(ThreadMask), .OutValid(OutValid), .OutReady(OutReady),
    .ALUOut(ALUOut), .LaneMaskOut(LaneMaskOut), .NZP(NZP)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected payload computed from the input fields.
  function automatic logic [T*W-1:0] exp_payload(input logic mux, input logic [T*W-1:0] a,
                                                 input logic [T*3-1:0] c, input logic [T-1:0] m);
    logic [T*W-1:0] r;
    r = '0;
    for (int t = 0; t < T; t++) begin
      if (m[t]) begin
        if (mux) begin
          r[t*W + 0] = c[t*3 + 2];
          r[t*W + 1] = c[t*3 + 1];
          r[t*W + 2] = c[t*3 + 0];
        end else begin
          r[t*W +: W] = a[t*W +: W];
        end
      end
    end
    return r;
  endfunction

  function automatic logic model_ready();
`ifdef ALU_RESULT_STAGE_SKID_EN
    return !reset && (q.size() < 2);
`else
    return !reset && ((q.size() == 0) || OutReady);
`endif
  endfunction

  task automatic drive(input logic v, input logic mux, input logic [T*W-1:0] a,
                       input logic [T*3-1:0] c, input logic [T-1:0] m);
    InValid      = v;
    ALUOutputMux = mux;
    ArithOut     = a;
    CmpOut       = c;
    ThreadMask   = m;
  endtask

  // Compare outputs against the model mid-cycle, then advance one edge.
  task automatic cycle();
    bit      acc;
    bit      drn;
    bundle_t b;
    #1;
    check("in_ready", InReady, model_ready());
    check("out_valid", OutValid, q.size() != 0);
    if (q.size() != 0) begin
      check("alu_out", ALUOut, q[0].data);
      check("lane_mask", LaneMaskOut, q[0].mask);
    end
    check("nzp", NZP, exp_nzp);
    acc = InValid && model_ready();
    drn = (q.size() != 0) && OutReady;
    @(posedge clk);
    if (reset) begin
      q.delete();
      exp_nzp = '0;
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        b.data = exp_payload(ALUOutputMux, ArithOut, CmpOut, ThreadMask);
        b.mask = ThreadMask;
        q.push_back(b);
        if (ALUOutputMux) begin
          for (int t = 0; t < T; t++)
            if (ThreadMask[t]) exp_nzp[t*3 +: 3] = CmpOut[t*3 +: 3];
        end
      end
    end
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    OutReady = 1'b1;
    exp_nzp  = '0;
    drive(1'b0, 1'b0, '0, '0, '0);

    // Reset state
    @(posedge clk);
    #1;
    check("rst_out_valid", OutValid, 1'b0);
    check("rst_alu_out", ALUOut, 32'h0);
    check("rst_lane_mask", LaneMaskOut, 4'h0);
    check("rst_nzp", NZP, 12'h0);
    check("rst_in_ready", InReady, 1'b0);
    cycle();
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", InReady, 1'b1);

    // Arithmetic mode, all lanes active
    drive(1'b1, 1'b0, 32'h44332211, 12'hFFF, 4'hF);
    cycle();
    drive(1'b0, 1'b0, '0, '0, '0);
    check("arith_out", ALUOut, 32'h44332211);
    check("arith_valid", OutValid, 1'b1);
    check("arith_nzp", NZP, 12'h0);
    cycle();

    // Preload lane 3 NZP, then flag mode with lane 3 masked
    drive(1'b1, 1'b1, '0, 12'b010_000_000_000, 4'b1000);
    cycle();
    drive(1'b1, 1'b1, 32'hDEADBEEF, 12'b111_001_010_100, 4'b0111);
    cycle();
    drive(1'b0, 1'b0, '0, '0, '0);
    check("flag_out", ALUOut, 32'h00040201);
    check("flag_mask", LaneMaskOut, 4'b0111);
    check("flag_nzp", NZP, 12'b010_001_010_100);
    cycle();
    cycle();

    // Backpressure: A, B, C with OutReady low
    OutReady = 1'b0;
    drive(1'b1, 1'b0, 32'hA0A1A2A3, '0, 4'hF);
    cycle();
    drive(1'b1, 1'b0, 32'hB0B1B2B3, '0, 4'hF);
    cycle();
    drive(1'b1, 1'b0, 32'hC0C1C2C3, '0, 4'hF);
`ifdef ALU_RESULT_STAGE_SKID_EN
    #1;
    check("bp_full_ready", InReady, 1'b0);
    check("bp_head_a", ALUOut, 32'hA0A1A2A3);
`endif
    cycle();
    OutReady = 1'b1;
`ifdef ALU_RESULT_STAGE_SKID_EN
    #1;
    check("bp_full_drain_ready", InReady, 1'b0);
`endif
    cycle();
    cycle();
    drive(1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 3; i++) cycle();

    // Streaming: 10 bundles back to back
    ov_count = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, $urandom, '0, 4'hF);
      cycle();
      if (OutValid === 1'b1) ov_count++;
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    check("stream_valid_cycles", ov_count, 10);
    cycle();
    cycle();

    // Reset mid-operation with buffered bundles and nonzero NZP
    OutReady = 1'b0;
    drive(1'b1, 1'b1, '0, 12'b100_010_001_100, 4'hF);
    cycle();
    drive(1'b1, 1'b0, 32'h55667788, '0, 4'hF);
    cycle();
    check("pre_rst_nzp", NZP, 12'b100_010_001_100);
    reset = 1'b1;
    drive(1'b1, 1'b0, 32'h99AABBCC, '0, 4'hF);
    cycle();
    reset    = 1'b0;
    OutReady = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0);
    #1;
    check("mid_rst_out_valid", OutValid, 1'b0);
    check("mid_rst_nzp", NZP, 12'h0);
    check("mid_rst_in_ready", InReady, 1'b1);
    cycle();

    // Accept and drain in the same cycle at occupancy 1
    drive(1'b1, 1'b0, 32'h0E0E0E0E, '0, 4'hF);
    cycle();
    drive(1'b1, 1'b0, 32'h0F0F0F0F, '0, 4'b0101);
    #1;
    check("replace_in_ready", InReady, 1'b1);
    cycle();
    drive(1'b0, 1'b0, '0, '0, '0);
    check("replace_out", ALUOut, 32'h000F000F);
    check("replace_valid", OutValid, 1'b1);
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
